// File: rtl/reg_file_rat_pkg.sv
// Shared constants for the register file / RAT and the ROB it talks to.
// Defaults here feed the parameters of the interface, the top and the read port.
package reg_file_rat_pkg;

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int REG_W  = $clog2(REG_N);

  localparam int ROB_N  = 16;
  localparam int ROB_W  = $clog2(ROB_N);

  localparam logic [ROB_W-1:0] NOT_RENAMED = '0;

endpackage

// File: rtl/reg_file_rat_if.sv
// Decoder lookup/rename request, registered operand response and ROB commit bus.
// The master side is the decoder/ROB, the slave side is the register file.
interface reg_file_rat_if
  import reg_file_rat_pkg::*;
#(
  parameter int DATA_W = reg_file_rat_pkg::DATA_W,
  parameter int REG_W  = reg_file_rat_pkg::REG_W,
  parameter int ROB_W  = reg_file_rat_pkg::ROB_W
);

  logic              dec_valid;
  logic [REG_W-1:0]  dec_rs1_index;
  logic [REG_W-1:0]  dec_rs2_index;
  logic              dec_need_rs1;
  logic              dec_need_rs2;
  logic              dec_rd_valid;
  logic [REG_W-1:0]  dec_rd_index;
  logic [ROB_W-1:0]  dec_rd_rename;

  logic              out_valid;
  logic              rs1_renamed;
  logic [DATA_W-1:0] rs1_value;
  logic [ROB_W-1:0]  rs1_rename;
  logic              rs2_renamed;
  logic [DATA_W-1:0] rs2_value;
  logic [ROB_W-1:0]  rs2_rename;

  logic              rob_enable;
  logic [REG_W-1:0]  rob_commit_index;
  logic [ROB_W-1:0]  rob_commit_rename;
  logic [DATA_W-1:0] rob_commit_value;

  modport master (
    output dec_valid, dec_rs1_index, dec_rs2_index, dec_need_rs1, dec_need_rs2,
           dec_rd_valid, dec_rd_index, dec_rd_rename,
           rob_enable, rob_commit_index, rob_commit_rename, rob_commit_value,
    input  out_valid, rs1_renamed, rs1_value, rs1_rename,
           rs2_renamed, rs2_value, rs2_rename
  );

  modport slave (
    input  dec_valid, dec_rs1_index, dec_rs2_index, dec_need_rs1, dec_need_rs2,
           dec_rd_valid, dec_rd_index, dec_rd_rename,
           rob_enable, rob_commit_index, rob_commit_rename, rob_commit_value,
    output out_valid, rs1_renamed, rs1_value, rs1_rename,
           rs2_renamed, rs2_value, rs2_rename
  );

endinterface

// File: rtl/reg_file_rat_port.sv
// One combinational read port: commit bypass, then need/x0 masking.
// The top registers its result into the response outputs.
module reg_file_rat_port
  import reg_file_rat_pkg::*;
#(
  parameter int               DATA_W      = reg_file_rat_pkg::DATA_W,
  parameter int               REG_W       = reg_file_rat_pkg::REG_W,
  parameter int               ROB_W       = reg_file_rat_pkg::ROB_W,
  parameter logic [ROB_W-1:0] NOT_RENAMED = reg_file_rat_pkg::NOT_RENAMED
) (
  input  logic [REG_W-1:0]  index,
  input  logic              need,
  input  logic [DATA_W-1:0] stored_value,
  input  logic              stored_renamed,
  input  logic [ROB_W-1:0]  stored_tag,
  input  logic              commit_en,
  input  logic [REG_W-1:0]  commit_index,
  input  logic [ROB_W-1:0]  commit_rename,
  input  logic [DATA_W-1:0] commit_value,
  output logic              renamed,
  output logic [DATA_W-1:0] value,
  output logic [ROB_W-1:0]  rename
);

  logic bypass;

  // A commit only resolves the operand if it retires the very producer we would wait on.
  assign bypass = commit_en && (commit_index == index) && (index != '0)
                  && stored_renamed && (stored_tag == commit_rename);

  always_comb begin
    renamed = stored_renamed;
    value   = stored_value;
    rename  = stored_renamed ? stored_tag : NOT_RENAMED;
    if (bypass) begin
      renamed = 1'b0;
      value   = commit_value;
      rename  = NOT_RENAMED;
    end
    if (!need) begin
      renamed = 1'b0;
      rename  = NOT_RENAMED;
    end
    if (index == '0) begin
      renamed = 1'b0;
      value   = '0;
      rename  = NOT_RENAMED;
    end
  end

endmodule

// File: rtl/reg_file_rat.sv
// Architectural register file plus register alias table for the Tomasulo core.
// Answers two operand lookups per cycle, records renames and retires ROB commits.
module reg_file_rat
  import reg_file_rat_pkg::*;
#(
  parameter int               DATA_W      = reg_file_rat_pkg::DATA_W,
  parameter int               REG_N       = reg_file_rat_pkg::REG_N,
  parameter int               REG_W       = reg_file_rat_pkg::REG_W,
  parameter int               ROB_W       = reg_file_rat_pkg::ROB_W,
  parameter logic [ROB_W-1:0] NOT_RENAMED = reg_file_rat_pkg::NOT_RENAMED
) (
  input logic           clk,
  input logic           rst,
  input logic           rdy,
  input logic           jump_wrong,
  reg_file_rat_if.slave bus
);

  logic [DATA_W-1:0] values  [REG_N];
  logic              renamed [REG_N];
  logic [ROB_W-1:0]  tags    [REG_N];

  logic              rd1_renamed, rd2_renamed;
  logic [DATA_W-1:0] rd1_value,   rd2_value;
  logic [ROB_W-1:0]  rd1_rename,  rd2_rename;

  reg_file_rat_port #(
    .DATA_W(DATA_W), .REG_W(REG_W), .ROB_W(ROB_W), .NOT_RENAMED(NOT_RENAMED)
  ) u_port1 (
    .index         (bus.dec_rs1_index),
    .need          (bus.dec_need_rs1),
    .stored_value  (values[bus.dec_rs1_index]),
    .stored_renamed(renamed[bus.dec_rs1_index]),
    .stored_tag    (tags[bus.dec_rs1_index]),
    .commit_en     (bus.rob_enable),
    .commit_index  (bus.rob_commit_index),
    .commit_rename (bus.rob_commit_rename),
    .commit_value  (bus.rob_commit_value),
    .renamed       (rd1_renamed),
    .value         (rd1_value),
    .rename        (rd1_rename)
  );

  reg_file_rat_port #(
    .DATA_W(DATA_W), .REG_W(REG_W), .ROB_W(ROB_W), .NOT_RENAMED(NOT_RENAMED)
  ) u_port2 (
    .index         (bus.dec_rs2_index),
    .need          (bus.dec_need_rs2),
    .stored_value  (values[bus.dec_rs2_index]),
    .stored_renamed(renamed[bus.dec_rs2_index]),
    .stored_tag    (tags[bus.dec_rs2_index]),
    .commit_en     (bus.rob_enable),
    .commit_index  (bus.rob_commit_index),
    .commit_rename (bus.rob_commit_rename),
    .commit_value  (bus.rob_commit_value),
    .renamed       (rd2_renamed),
    .value         (rd2_value),
    .rename        (rd2_rename)
  );

  // Rename is written after the commit so a same-cycle new rename wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        values[i]  <= '0;
        renamed[i] <= 1'b0;
        tags[i]    <= NOT_RENAMED;
      end
      bus.out_valid   <= 1'b0;
      bus.rs1_renamed <= 1'b0;
      bus.rs1_value   <= '0;
      bus.rs1_rename  <= NOT_RENAMED;
      bus.rs2_renamed <= 1'b0;
      bus.rs2_value   <= '0;
      bus.rs2_rename  <= NOT_RENAMED;
    end else if (rdy) begin
      if (jump_wrong) begin
        for (int i = 0; i < REG_N; i++) begin
          renamed[i] <= 1'b0;
          tags[i]    <= NOT_RENAMED;
        end
        bus.out_valid <= 1'b0;
      end else begin
        bus.out_valid <= bus.dec_valid;
        if (bus.dec_valid) begin
          bus.rs1_renamed <= rd1_renamed;
          bus.rs1_value   <= rd1_value;
          bus.rs1_rename  <= rd1_rename;
          bus.rs2_renamed <= rd2_renamed;
          bus.rs2_value   <= rd2_value;
          bus.rs2_rename  <= rd2_rename;
        end
        if (bus.rob_enable && (bus.rob_commit_index != '0)) begin
          values[bus.rob_commit_index] <= bus.rob_commit_value;
          if (tags[bus.rob_commit_index] == bus.rob_commit_rename) begin
            renamed[bus.rob_commit_index] <= 1'b0;
            tags[bus.rob_commit_index]    <= NOT_RENAMED;
          end
        end
        if (bus.dec_valid && bus.dec_rd_valid && (bus.dec_rd_index != '0)) begin
          renamed[bus.dec_rd_index] <= 1'b1;
          tags[bus.dec_rd_index]    <= bus.dec_rd_rename;
        end
      end
    end
  end

endmodule

// File: doc/reg_file_rat.md
Name: reg_file_rat

Overview:
Parametrised architectural register file with a register alias table (RAT) for the Tomasulo core. It sits between decoder and ROB. It answers two source-operand lookups per decoded instruction, returning either a committed value or the ROB tag of the pending producer. It records the destination rename and retires ROB commits.
This generation adds the following:
- Clock-synchronous lookups with a one-cycle registered response and valid flag.
- Same-cycle commit bypass.
- Tag-checked rename clearing on commit.
- Generic register count and data/tag widths.

Parameters:
DATA_W, 32, register data width
REG_N, 32, number of architectural registers (power of two)
REG_W, 5, log2(REG_N)
ROB_W, 4, ROB tag width
NOT_RENAMED, 0, tag value output when an operand is not renamed

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous active-high
rdy  in  1  global enable; when low, all state and outputs hold
jump_wrong  in  1  mispredict flush
dec_valid  in  1  lookup request this cycle
dec_rs1_index  in  REG_W  source 1 index
dec_rs2_index  in  REG_W  source 2 index
dec_need_rs1  in  1  instruction uses rs1
dec_need_rs2  in  1  instruction uses rs2
dec_rd_valid  in  1  instruction writes rd
dec_rd_index  in  REG_W  destination index
dec_rd_rename  in  ROB_W  ROB tag of this instruction
out_valid  out  1  response valid (one-cycle pulse)
rs1_renamed  out  1  rs1 waits on ROB
rs1_value  out  DATA_W  rs1 value
rs1_rename  out  ROB_W  rs1 producer tag
rs2_renamed  out  1  rs2 waits on ROB
rs2_value  out  DATA_W  rs2 value
rs2_rename  out  ROB_W  rs2 producer tag
rob_enable  in  1  commit strobe
rob_commit_index  in  REG_W  committed rd
rob_commit_rename  in  ROB_W  committed tag
rob_commit_value  in  DATA_W  committed value

Behaviour:
Clock, reset and enable:
- One clock (clk). Reset is synchronous, active-high (rst).
- Reset: all values 0, all renamed flags 0, all tags NOT_RENAMED. All outputs are 0; out_valid=0; tag outputs are NOT_RENAMED.
- rdy=0: nothing updates, and outputs hold their values (out_valid included).

Lookup (rdy=1, jump_wrong=0, dec_valid=1):
- Response is registered and appears on the next cycle, with out_valid=1 for exactly one cycle.
- The read uses pre-edge state, with commit bypass. If rob_enable is high, commit_index equals rsX (rsX!=0), the register is renamed, and its tag equals commit_rename, then the response is renamed=0 and value=commit_value.
- If need_rsX=0: renamed=0 and rename=NOT_RENAMED. The value field still carries the register value.
- rsX=0: always renamed=0, value=0.
- Rename update: if dec_rd_valid=1 and rd!=0, the rd tag is set to dec_rd_rename and renamed is set to 1. This applies at the same edge, after the read.
- rd==rs1 or rd==rs2 therefore returns the old mapping, never its own tag.

Commit (rdy=1, jump_wrong=0, rob_enable=1):
- If commit_index!=0, the value is written.
- renamed is cleared and the tag is set to NOT_RENAMED only if the stored tag equals commit_rename; otherwise the newer rename is kept.
- x0 is never written, renamed, or tagged.
- Commit and a new rename to the same register in the same cycle: the value is written and the new rename wins.

Flush (rdy=1, jump_wrong=1):
- All renamed flags are cleared and all tags set to NOT_RENAMED; values are unchanged.
- dec_valid and rob_enable are ignored; out_valid=0 next cycle.
- The ROB never commits in the flush cycle.

No lookup this cycle: out_valid=0 next cycle. The data outputs hold.

Decomposition:
- Shared package/define file holds DATA_W, REG_W, ROB_W, NOT_RENAMED and the REG_N defaults, alongside the existing ROB constants.
- One sub-module is natural: reg_file_rat_port (one read port, holding the bypass mux and the need/x0 masking), instantiated twice.
- The storage arrays stay in the top module.

Test Plan:
1. Reset, then look up rs1=5 and rs2=0 -> next cycle: out_valid=1, both renamed=0, both values 0, both tags 0.
2. Rename x3 to tag 7, then on the next cycle look up rs1=3 -> rs1_renamed=1, rs1_rename=7.
3. Commit x3 tag 7 with value 0xDEAD in the same cycle as a lookup of rs1=3 -> rs1_renamed=0, rs1_value=0xDEAD (bypass); x3 is then clean.
4. Rename x4 to tag 2, then rename x4 to tag 5, then commit x4 tag 2 with value 0x11 -> x4 value=0x11, still renamed with tag 5.
5. rs1=rd=6 with rd tag 9 while x6 is clean -> response renamed=0 with the old value; a later lookup gives tag 9.
6. With x1, x2 and x7 renamed, assert jump_wrong for one cycle together with dec_valid -> out_valid=0. Subsequent lookups show renamed=0 and the previous committed values. rd=0 with dec_rd_valid is ignored.
